// File: rtl/spi_sp_receiver.sv
// Serial-to-parallel receiver: MSB-first word capture qualified by en, with a
// single-entry output holding register, valid/ack handshake and sticky overrun.
module spi_sp_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_valid, w_valid_next;
  logic             r_overrun, w_overrun_next;
  logic             w_word_done;
  logic [WIDTH-1:0] w_word;

  // The bit being sampled this edge always lands at the LSB.
  assign w_word = {r_shift[WIDTH-2:0], din};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_cnt     <= w_cnt_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_cnt_next     = r_cnt;
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;
    w_word_done    = 1'b0;

    case (r_state)
      IDLE: begin
        if (en) begin
          w_shift_next = {{(WIDTH-1){1'b0}}, din};
          w_cnt_next   = CW'(1);
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!en) begin
          // Abort: partial frame is discarded without touching the output side.
          w_state_next = IDLE;
          w_shift_next = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == LAST_CNT) begin
          w_word_done  = 1'b1;
          w_state_next = IDLE;
          w_shift_next = '0;
          w_cnt_next   = '0;
        end else begin
          w_shift_next = w_word;
          w_cnt_next   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // An ack on the completing edge frees the holding register in time.
    if (w_word_done) begin
      if (!r_valid || ack) begin
        w_data_next  = w_word;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (ack && r_valid) begin
      w_valid_next = 1'b0;
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign busy    = (r_state == SHIFT);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_spi_sp_receiver.sv
// Directed bench for spi_sp_receiver (WIDTH=4): one linear stimulus sequence,
// immediate assertions against hand-computed expectations.
module tb_spi_sp_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       din   = 1'b0;
  logic       ack   = 1'b0;
  logic [3:0] data;
  logic       valid;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  spi_sp_receiver #(.WIDTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .din     (din),
    .ack     (ack),
    .data    (data),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  // Drive inputs mid-cycle, then sample outputs 1 time unit after the edge.
  task automatic step(input logic e, input logic d, input logic a);
    @(negedge clock);
    en  = e;
    din = d;
    ack = a;
    @(posedge clock);
    #1;
    $display("step en=%0b din=%0b ack=%0b rst=%0b -> data=%b valid=%0b busy=%0b overrun=%0b",
             e, d, a, reset, data, valid, busy, overrun);
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] d, input logic v,
                           input logic b, input logic o);
    check({tag, "_data"},    data,          d);
    check({tag, "_valid"},   {3'b0, valid}, {3'b0, v});
    check({tag, "_busy"},    {3'b0, busy},  {3'b0, b});
    check({tag, "_overrun"}, {3'b0, overrun}, {3'b0, o});
  endtask

  initial begin
    // Reset state, with en/din/ack all high to show reset overrides them.
    do_reset();
    check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Idle hold with en=0.
    step(1'b0, 1'b1, 1'b0);
    check_all("idle_hold", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Basic word 1110.
    step(1'b1, 1'b1, 1'b0);
    check_all("basic_b1", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("basic_b3", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("basic_done", 4'b1110, 1'b1, 1'b0, 1'b0);

    // Ack clear with en=0, then ack while valid=0 is ignored.
    step(1'b0, 1'b0, 1'b1);
    check_all("ack_clear", 4'b1110, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check_all("ack_ignored", 4'b1110, 1'b0, 1'b0, 1'b0);

    // Back-to-back 1110 then 0101; ack on the edge completing the second word.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("b2b_w1", 4'b1110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("b2b_gapless", 4'b1110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_all("b2b_w2", 4'b0101, 1'b1, 1'b0, 1'b0);

    // Overrun: same stimulus with no ack.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("ovr_w1", 4'b1110, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("ovr_w2", 4'b1110, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_all("ovr_sticky_ack", 4'b1110, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("ovr_sticky_word", 4'b0110, 1'b1, 1'b0, 1'b1);

    // Abort after two bits, then a clean 0011 frame.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("abort_mid", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_all("abort", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("abort_next", 4'b0011, 1'b1, 1'b0, 1'b0);

    // Build valid=1 and overrun=1, then reset three bits into a frame.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("pre_rst_ovr", 4'b0011, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("pre_rst_mid", 4'b0011, 1'b1, 1'b1, 1'b1);
    do_reset();
    check_all("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("post_rst_b3", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("post_rst_word", 4'b1001, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
